mbr_mem_port: RTL and testbench

- Memory buffer register (MBR) together with its memory-side handshake controller for the 16-bit control-word CPU.
- Runs microcoded read and write cycles to external RAM using a four-phase REQ/ACK handshake, at the address held in the MAR.
- Holds read data on MBR_OUT, which feeds the buffer register's MBR_IN. Accepts store data from the accumulator.
- Detects a missing or stuck ACK with a timeout and reports it on a sticky error flag.

---
 rtl/mbr_mem_port.sv | 118 +++++++++++
 tb/tb_mbr_mem_port.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mbr_mem_port.sv
// ============================================================================
// mbr_mem_port : memory buffer register and four-phase REQ/ACK RAM controller
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mbr_mem_port #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       CON,
  input  logic [ADDR_W-1:0] MAR_IN,
  input  logic [DATA_W-1:0] ACC_IN,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [DATA_W-1:0] MBR_OUT,
  output logic              BUSY,
  output logic              ERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD_REQ = 2'd1,
    S_WR_REQ = 2'd2,
    S_REL    = 2'd3
  } state_t;

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  state_t     r_state;
  logic [7:0] r_cnt;

  logic       w_rd;
  logic       w_wr;
  logic       w_ld;
  logic [7:0] w_cnt_nxt;
  logic       w_expired;
  logic       w_unused;

  assign w_rd      = CON[3];
  assign w_wr      = CON[4];
  assign w_ld      = CON[6];
  assign w_unused  = ^{CON[31:7], CON[5], CON[2:0]};
  assign w_cnt_nxt = r_cnt + 8'd1;
  // Abort on the edge where this wait cycle would bring the count to TIMEOUT
  assign w_expired = (w_cnt_nxt >= C_TIMEOUT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      MBR_OUT   <= '0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd && w_wr) begin
            ERR <= 1'b1;
          end else if (w_rd || w_wr) begin
            MEM_ADDR <= MAR_IN;
            MEM_WE   <= w_wr;
            MEM_REQ  <= 1'b1;
            BUSY     <= 1'b1;
            ERR      <= 1'b0;
            r_cnt    <= 8'd0;
            if (w_wr) MEM_WDATA <= MBR_OUT;
            r_state  <= w_wr ? S_WR_REQ : S_RD_REQ;
          end else if (w_ld) begin
            MBR_OUT <= ACC_IN;
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          if (MEM_ACK) begin
            if (r_state == S_RD_REQ) MBR_OUT <= MEM_RDATA;
            MEM_REQ <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_REL;
          end else if (w_expired) begin
            MEM_REQ <= 1'b0;
            ERR     <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= S_REL;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_REL: begin
          if (!MEM_ACK || w_expired) begin
            if (MEM_ACK) ERR <= 1'b1;
            MEM_WE  <= 1'b0;
            BUSY    <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mbr_mem_port.sv
// ============================================================================
// tb_mbr_mem_port : directed self-checking bench for mbr_mem_port
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mbr_mem_port;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] CON = 32'd0;
  logic [7:0]  MAR_IN = 8'd0;
  logic [15:0] ACC_IN = 16'd0;
  logic [15:0] MEM_RDATA = 16'd0;
  logic        MEM_ACK = 1'b0;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [7:0]  MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [15:0] MBR_OUT;
  logic        BUSY;
  logic        ERR;

  logic        ack_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  mbr_mem_port #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .CON(CON), .MAR_IN(MAR_IN), .ACC_IN(ACC_IN),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MBR_OUT(MBR_OUT), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // RAM model: ACK follows REQ half a cycle later, so it is seen one edge after REQ rises
  always @(negedge CLK) MEM_ACK = ack_en && MEM_REQ;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if ({MEM_REQ, MEM_WE, BUSY, ERR} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {MEM_REQ, MEM_WE, BUSY, ERR}); end
    n_vec++; if ({MEM_ADDR, MEM_WDATA, MBR_OUT} !== 40'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", {MEM_ADDR, MEM_WDATA, MBR_OUT}); end
    tick();
    RST = 1'b0;
    CON = 32'h40; ACC_IN = 16'hBEEF;
    tick();
    CON = 32'd0;
    n_vec++; if (MBR_OUT !== 16'hBEEF) begin n_err++; $display("FAIL acc_load: got %h want beef", MBR_OUT); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL acc_load_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_read();
    ack_en = 1'b1; MEM_RDATA = 16'h1234; MAR_IN = 8'h2A; CON = 32'h8;
    tick();
    CON = 32'd0;
    n_vec++; if ({MEM_REQ, MEM_WE, BUSY} !== 3'b101) begin n_err++; $display("FAIL rd_accept: got %b want 101", {MEM_REQ, MEM_WE, BUSY}); end
    n_vec++; if (MEM_ADDR !== 8'h2A) begin n_err++; $display("FAIL rd_addr: got %h want 2a", MEM_ADDR); end
    tick();
    n_vec++; if (MBR_OUT !== 16'h1234) begin n_err++; $display("FAIL rd_data: got %h want 1234", MBR_OUT); end
    n_vec++; if ({MEM_REQ, BUSY} !== 2'b01) begin n_err++; $display("FAIL rd_rel: got %b want 01", {MEM_REQ, BUSY}); end
    tick();
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rd_done_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_write();
    // MBR was restored to BEEF by the load below; read left 1234
    CON = 32'h40; ACC_IN = 16'hBEEF;
    tick();
    MAR_IN = 8'h05; CON = 32'h10;
    tick();
    n_vec++; if ({MEM_REQ, MEM_WE, BUSY} !== 3'b111) begin n_err++; $display("FAIL wr_accept: got %b want 111", {MEM_REQ, MEM_WE, BUSY}); end
    n_vec++; if (MEM_WDATA !== 16'hBEEF) begin n_err++; $display("FAIL wr_wdata: got %h want beef", MEM_WDATA); end
    // ACC load and new address while busy must be ignored
    CON = 32'h40; ACC_IN = 16'h0F0F; MAR_IN = 8'h77; MEM_RDATA = 16'hDEAD;
    tick();
    tick();
    CON = 32'd0;
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL wr_done_busy: got %b want 0", BUSY); end
    n_vec++; if (MEM_ADDR !== 8'h05) begin n_err++; $display("FAIL wr_addr_hold: got %h want 05", MEM_ADDR); end
    n_vec++; if (MEM_WDATA !== 16'hBEEF) begin n_err++; $display("FAIL wr_wdata_hold: got %h want beef", MEM_WDATA); end
    n_vec++; if (MBR_OUT !== 16'hBEEF) begin n_err++; $display("FAIL wr_mbr_hold: got %h want beef", MBR_OUT); end
    n_vec++; if (MEM_WE !== 1'b0) begin n_err++; $display("FAIL wr_we_clear: got %b want 0", MEM_WE); end
  endtask

  task automatic test_timeout();
    ack_en = 1'b0; MAR_IN = 8'h33; CON = 32'h8;
    tick();
    CON = 32'd0;
    tick(); tick(); tick();
    n_vec++; if (MEM_REQ !== 1'b1) begin n_err++; $display("FAIL to_wait3: got %b want 1", MEM_REQ); end
    tick();
    n_vec++; if ({MEM_REQ, ERR, BUSY} !== 3'b011) begin n_err++; $display("FAIL to_abort: got %b want 011", {MEM_REQ, ERR, BUSY}); end
    n_vec++; if (MBR_OUT !== 16'hBEEF) begin n_err++; $display("FAIL to_mbr: got %h want beef", MBR_OUT); end
    tick();
    n_vec++; if ({BUSY, ERR} !== 2'b01) begin n_err++; $display("FAIL to_idle: got %b want 01", {BUSY, ERR}); end
  endtask

  task automatic test_conflict_and_recover();
    ERR_clear_check: begin
      CON = 32'h58; ACC_IN = 16'h0F0F;
      tick();
      CON = 32'd0;
      n_vec++; if ({MEM_REQ, BUSY, ERR} !== 3'b001) begin n_err++; $display("FAIL conflict: got %b want 001", {MEM_REQ, BUSY, ERR}); end
      n_vec++; if (MBR_OUT !== 16'hBEEF) begin n_err++; $display("FAIL conflict_mbr: got %h want beef", MBR_OUT); end
      CON = 32'h40; ACC_IN = 16'hA5A5;
      tick();
      n_vec++; if ({MBR_OUT, ERR} !== {16'hA5A5, 1'b1}) begin n_err++; $display("FAIL ld_keeps_err: got %h want a5a51", {MBR_OUT, ERR}); end
      ack_en = 1'b1; MEM_RDATA = 16'h5678; MAR_IN = 8'h10; CON = 32'h8;
      tick();
      CON = 32'd0;
      n_vec++; if ({MEM_REQ, ERR} !== 2'b10) begin n_err++; $display("FAIL recover_accept: got %b want 10", {MEM_REQ, ERR}); end
      tick(); tick();
      n_vec++; if ({MBR_OUT, BUSY, ERR} !== {16'h5678, 2'b00}) begin n_err++; $display("FAIL recover_done: got %h want 567800", {MBR_OUT, BUSY, ERR}); end
    end
  endtask

  task automatic test_async_reset();
    ack_en = 1'b0; MAR_IN = 8'h44; CON = 32'h8;
    tick();
    CON = 32'd0;
    n_vec++; if (MEM_REQ !== 1'b1) begin n_err++; $display("FAIL ar_req: got %b want 1", MEM_REQ); end
    #2 RST = 1'b1;
    #1;
    n_vec++; if ({MEM_REQ, BUSY} !== 2'b00) begin n_err++; $display("FAIL ar_immediate: got %b want 00", {MEM_REQ, BUSY}); end
    n_vec++; if (MBR_OUT !== 16'd0) begin n_err++; $display("FAIL ar_mbr: got %h want 0", MBR_OUT); end
    #1 RST = 1'b0;
    tick(); tick();
    n_vec++; if ({MEM_REQ, BUSY, ERR} !== 3'b000) begin n_err++; $display("FAIL ar_idle: got %b want 000", {MEM_REQ, BUSY, ERR}); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_conflict_and_recover();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
